// File: rtl/iir_biquad_sequencer.sv
// Direct-form-I biquad sequencer: drives the filter_mem_block delay line and runs the 5-tap MAC with rounding and saturation.
// Latency 9 cycles from the accept cycle to out_valid; one sample is processed every 10 cycles.
// Backpressure: in_ready is high only in IDLE, and in_valid is ignored in every other state.
module iir_biquad_sequencer #(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [COEF_W-1:0] b0,
    input  logic signed [COEF_W-1:0] b1,
    input  logic signed [COEF_W-1:0] b2,
    input  logic signed [COEF_W-1:0] a1,
    input  logic signed [COEF_W-1:0] a2,
    output logic                     x_enable,
    output logic                     y_enable,
    output logic [2:0]               dir,
    output logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y,
    input  logic signed [DATA_W-1:0] mem_out,
    output logic                     out_valid,
    output logic                     out_sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + 3;

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_FINAL,
        S_WRITE
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [COEF_W-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;
    logic signed [ACC_W-1:0]  acc;
    logic [2:0]               tap_k;

    logic                     in_ready_nxt;
    logic                     x_enable_nxt;
    logic                     y_enable_nxt;
    logic [2:0]               dir_nxt;
    logic                     accept;
    logic                     acc_clr;
    logic                     acc_en;
    logic                     final_ld;

    logic signed [COEF_W-1:0] coef_sel;
    logic                     tap_sub;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  rnd;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [DATA_W-1:0] sat_val;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid && in_ready) next_state = S_LOAD;
            S_LOAD:  next_state = S_ISSUE;
            S_ISSUE: if (dir == 3'd4) next_state = S_DRAIN;
            S_DRAIN: next_state = S_FINAL;
            S_FINAL: next_state = S_WRITE;
            S_WRITE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode: every port is registered, so the decode targets the coming state.
    always_comb begin
        in_ready_nxt = (next_state == S_IDLE);
        x_enable_nxt = (next_state == S_LOAD);
        y_enable_nxt = (next_state == S_WRITE);
        dir_nxt      = dir;
        if (next_state == S_ISSUE) begin
            dir_nxt = (state == S_ISSUE) ? dir + 3'd1 : 3'd0;
        end
        accept   = (state == S_IDLE) && in_valid && in_ready;
        acc_clr  = (state == S_LOAD);
        acc_en   = ((state == S_ISSUE) && (dir != 3'd0)) || (state == S_DRAIN);
        final_ld = (state == S_FINAL);
    end

    // mem_out lags dir by one cycle, so the coefficient is selected by the previous dir.
    always_comb begin
        coef_sel = '0;
        tap_sub  = 1'b0;
        case (tap_k)
            3'd0: coef_sel = c_b0;
            3'd1: coef_sel = c_b1;
            3'd2: coef_sel = c_b2;
            3'd3: begin coef_sel = c_a1; tap_sub = 1'b1; end
            3'd4: begin coef_sel = c_a2; tap_sub = 1'b1; end
            default: coef_sel = '0;
        endcase
    end

    // Feedback taps subtract the product instead of negating the coefficient, so a = -2^(COEF_W-1) cannot overflow.
    assign prod = PROD_W'(coef_sel) * PROD_W'(mem_out);

    always_comb begin
        rnd_sum = acc + HALF;
        rnd     = rnd_sum >>> FRAC_BITS;
        sat_hi  = (rnd > Y_MAX);
        sat_lo  = (rnd < Y_MIN);
        if (sat_hi) begin
            sat_val = Y_MAX[DATA_W-1:0];
        end else if (sat_lo) begin
            sat_val = Y_MIN[DATA_W-1:0];
        end else begin
            sat_val = rnd[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            x_enable  <= 1'b0;
            y_enable  <= 1'b0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            dir       <= 3'd0;
            tap_k     <= 3'd0;
            x         <= '0;
            y         <= '0;
            acc       <= '0;
            c_b0      <= '0;
            c_b1      <= '0;
            c_b2      <= '0;
            c_a1      <= '0;
            c_a2      <= '0;
        end else begin
            in_ready  <= in_ready_nxt;
            x_enable  <= x_enable_nxt;
            y_enable  <= y_enable_nxt;
            out_valid <= y_enable_nxt;
            dir       <= dir_nxt;
            tap_k     <= dir;
            if (accept) begin
                x    <= x_in;
                c_b0 <= b0;
                c_b1 <= b1;
                c_b2 <= b2;
                c_a1 <= a1;
                c_a2 <= a2;
            end
            if (acc_clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= tap_sub ? acc - ACC_W'(prod) : acc + ACC_W'(prod);
            end
            if (final_ld) begin
                y       <= sat_val;
                out_sat <= sat_hi || sat_lo;
            end else begin
                out_sat <= 1'b0;
            end
        end
    end

    a_push_exclusive: assert property (@(posedge clk) disable iff (reset) !(x_enable && y_enable));
    a_dir_range:      assert property (@(posedge clk) disable iff (reset) dir <= 3'd4);
    a_ready_idle:     assert property (@(posedge clk) disable iff (reset) in_ready == (state == S_IDLE));

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Bench for iir_biquad_sequencer with a behavioural filter_mem_block delay line.
module tb_iir_biquad_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in, b0, b1, b2, a1, a2;
    logic        x_enable, y_enable;
    logic [2:0]  dir;
    logic [31:0] x, y;
    logic [31:0] mem_out;
    logic        out_valid, out_sat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iir_biquad_sequencer #(.DATA_W(32), .COEF_W(32), .FRAC_BITS(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .x_enable(x_enable), .y_enable(y_enable), .dir(dir), .x(x), .y(y),
        .mem_out(mem_out), .out_valid(out_valid), .out_sat(out_sat)
    );

    // Delay line: x[n], x[n-1], x[n-2], y[n-1], y[n-2]; registered tap read.
    logic [31:0] mx0, mx1, mx2, my1, my2;
    always @(posedge clk) begin
        if (reset) begin
            mx0 <= 0; mx1 <= 0; mx2 <= 0; my1 <= 0; my2 <= 0; mem_out <= 0;
        end else begin
            if (x_enable) begin mx0 <= x; mx1 <= mx0; mx2 <= mx1; end
            if (y_enable) begin my1 <= y; my2 <= my1; end
            case (dir)
                3'd0: mem_out <= mx0;
                3'd1: mem_out <= mx1;
                3'd2: mem_out <= mx2;
                3'd3: mem_out <= my1;
                3'd4: mem_out <= my2;
                default: mem_out <= 32'hDEAD_BEEF;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("push_exclusive", 32'(x_enable & y_enable), 32'd0);
            chk("dir_range", 32'(dir > 3'd4), 32'd0);
        end
    end

    typedef struct {
        bit          rst;
        logic [31:0] b0, b1, b2, a1, a2, xv, ey;
        bit          es;
    } vec_t;

    vec_t vt[$];

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_x_enable"}, 32'(x_enable), 32'd0);
        chk({tag, "_y_enable"}, 32'(y_enable), 32'd0);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
        chk({tag, "_x"}, x, 32'd0);
        chk({tag, "_y"}, y, 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sat"}, 32'(out_sat), 32'd0);
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge of cycle 10.
    task automatic run_sample(input vec_t v, input int idx);
        b0 = v.b0; b1 = v.b1; b2 = v.b2; a1 = v.a1; a2 = v.a2;
        x_in = v.xv;
        in_valid = 1'b1;
        chk($sformatf("v%0d_c0_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        b0 = $urandom(); b1 = $urandom(); b2 = $urandom(); a1 = $urandom(); a2 = $urandom();
        x_in = $urandom();
        chk($sformatf("v%0d_c1_xen", idx), 32'(x_enable), 32'd1);
        chk($sformatf("v%0d_c1_x", idx), x, v.xv);
        chk($sformatf("v%0d_c1_ready", idx), 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_c%0d_dir", idx, k + 2), 32'(dir), 32'(k));
            chk($sformatf("v%0d_c%0d_xen", idx, k + 2), 32'(x_enable), 32'd0);
        end
        for (int c = 7; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d_c%0d_ovld", idx, c), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("v%0d_c9_ovld", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_c9_yen", idx), 32'(y_enable), 32'd1);
        chk($sformatf("v%0d_c9_y", idx), y, v.ey);
        chk($sformatf("v%0d_c9_sat", idx), 32'(out_sat), 32'(v.es));
        @(negedge clk);
        chk($sformatf("v%0d_c10_ready", idx), 32'(in_ready), 32'd1);
        chk($sformatf("v%0d_c10_ovld", idx), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d_c10_yhold", idx), y, v.ey);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; x_in = 0;
        b0 = 0; b1 = 0; b2 = 0; a1 = 0; a2 = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        //             rst  b0            b1            b2            a1            a2            x             y             sat
        vt.push_back('{1, 32'h0001_0000, 32'h0,       32'h0,       32'h0,       32'h0,       32'd5,        32'd5,        0});
        vt.push_back('{1, 32'h0001_0000, 32'h0,       32'h0,       32'hFFFF_8000, 32'h0,     32'h0001_0000, 32'h0001_0000, 0});
        vt.push_back('{0, 32'h0001_0000, 32'h0,       32'h0,       32'hFFFF_8000, 32'h0,     32'h0,        32'h0000_8000, 0});
        vt.push_back('{0, 32'h0001_0000, 32'h0,       32'h0,       32'hFFFF_8000, 32'h0,     32'h0,        32'h0000_4000, 0});
        vt.push_back('{1, 32'h0000_8000, 32'h0,       32'h0,       32'h0,       32'h0,       32'd3,        32'd2,        0});
        vt.push_back('{0, 32'h0000_8000, 32'h0,       32'h0,       32'h0,       32'h0,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 0});
        vt.push_back('{0, 32'h0000_8000, 32'h0,       32'h0,       32'h0,       32'h0,       32'hFFFF_FFFF, 32'h0,        0});
        vt.push_back('{0, 32'h0000_8000, 32'h0,       32'h0,       32'h0,       32'h0,       32'd1,        32'd1,        0});
        vt.push_back('{1, 32'h7FFF_FFFF, 32'h0,       32'h0,       32'h0,       32'h0,       32'h7FFF_FFFF, 32'h7FFF_FFFF, 1});
        vt.push_back('{0, 32'h7FFF_FFFF, 32'h0,       32'h0,       32'h0,       32'h0,       32'h8000_0000, 32'h8000_0000, 1});
        vt.push_back('{1, 32'h0001_0000, 32'h0,       32'h0,       32'h0,       32'h0,       32'h7FFF_FFFF, 32'h7FFF_FFFF, 0});
        vt.push_back('{0, 32'h0001_0000, 32'h0,       32'h0,       32'h0,       32'h0,       32'h8000_0000, 32'h8000_0000, 0});
        vt.push_back('{1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0,     32'h0,       32'd1,        32'd1,        0});
        vt.push_back('{0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0,     32'h0,       32'd10,       32'd12,       0});
        vt.push_back('{0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0,     32'h0,       32'd100,      32'd123,      0});
        vt.push_back('{1, 32'h0001_0000, 32'h0,       32'h0,       32'h0,       32'hFFFF_0000, 32'd7,        32'd7,        0});
        vt.push_back('{0, 32'h0001_0000, 32'h0,       32'h0,       32'h0,       32'hFFFF_0000, 32'd0,        32'd0,        0});
        vt.push_back('{0, 32'h0001_0000, 32'h0,       32'h0,       32'h0,       32'hFFFF_0000, 32'd0,        32'd7,        0});

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            run_sample(vt[i], i);
        end

        // Continuous in_valid: one accept every 10 cycles.
        do_reset();
        b0 = 32'h0001_0000; b1 = 0; b2 = 0; a1 = 0; a2 = 0;
        x_in = 32'd4;
        in_valid = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            chk($sformatf("cont_c%0d_ready", c), 32'(in_ready), 32'((c % 10) == 0));
            chk($sformatf("cont_c%0d_xen", c), 32'(x_enable), 32'((c % 10) == 1));
            chk($sformatf("cont_c%0d_ovld", c), 32'(out_valid), 32'((c % 10) == 9));
            if ((c % 10) == 9) chk($sformatf("cont_c%0d_y", c), y, 32'd4);
            if (c == 30) in_valid = 1'b0;
            @(negedge clk);
        end

        // Reset during cycle 5 aborts the sample.
        do_reset();
        b0 = 32'h0001_0000; x_in = 32'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("abort_p%0d_ovld", c), 32'(out_valid), 32'd0);
            chk($sformatf("abort_p%0d_yen", c), 32'(y_enable), 32'd0);
            chk($sformatf("abort_p%0d_ready", c), 32'(in_ready), 32'd1);
        end
        run_sample('{0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'd9, 32'd9, 0}, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
